alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit registered ALU. Takes an operand pair and opcode over a valid/ready input channel and returns a registered result with status flags over a valid/ready output channel. Single-cycle ops complete in one clock. MUL is a multi-cycle iterative shift-add that produces a full double-width product. Sits between an operand sequencer and a writeback stage, so it must tolerate backpressure.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_mul.sv | 46 ++++
 rtl/alu_pipe.sv | 171 +++++++++++++++++
 tb/tb_alu_pipe.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NAND = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_ASR  = 4'd11;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product add per clock,
// WIDTH clocks after i_start; o_done flags the final step.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH);

  logic               r_run;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH:0]     w_sum;

  // Upper half accumulates; lower half starts as the multiplier and is
  // shifted out one bit per step as the product shifts in.
  assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_mcand} : '0);
  assign o_done = r_run && (r_cnt == CW'(WIDTH-1));
  assign o_prod = r_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_p     <= '0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= i_a;
      r_p     <= {{WIDTH{1'b0}}, i_b};
    end else if (r_run) begin
      r_p   <= {w_sum, r_p[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus a multi-cycle MUL,
// with a registered result/flag stage that holds under backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  state_t             r_state, w_state_nxt;
  logic               r_vld, r_err;
  logic [WIDTH-1:0]   r_y, r_yhi;
  logic [3:0]         r_flags;

  logic               w_acc, w_out_free, w_mul_start, w_ld_alu, w_ld_mul, w_load;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_t;
  logic [WIDTH-1:0]   w_ay, w_ny, w_nyhi;
  logic               w_ac, w_av, w_aerr, w_nerr;
  logic [3:0]         w_nflags;

  // Gated by rst so every output reads 0 while reset is held.
  assign w_out_free  = !r_vld || out_ready;
  assign in_ready    = rst && (r_state == IDLE) && w_out_free;
  assign w_acc       = in_valid && in_ready;
  assign w_mul_start = w_acc && (op == OP_MUL);
  assign w_ld_alu    = w_acc && (op != OP_MUL);
  assign w_ld_mul    = (r_state == DONE) && w_out_free;
  assign w_load      = w_ld_alu || w_ld_mul;
  assign w_sh        = b[SHW-1:0];

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_mul_start),
    .i_a    (a),
    .i_b    (b),
    .o_done (w_mul_done),
    .o_prod (w_prod)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_mul_start) w_state_nxt = MULT;
      MULT:    if (w_mul_done)  w_state_nxt = DONE;
      DONE:    if (w_out_free)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shifts are done on a WIDTH+1 vector so the last bit out lands in the
  // spare bit; a zero amount leaves that bit 0.
  always_comb begin
    w_t    = '0;
    w_ay   = '0;
    w_ac   = 1'b0;
    w_av   = 1'b0;
    w_aerr = 1'b0;
    case (op)
      OP_AND:  w_ay = a & b;
      OP_OR:   w_ay = a | b;
      OP_NAND: w_ay = ~(a & b);
      OP_NOR:  w_ay = ~(a | b);
      OP_NOT:  w_ay = ~a;
      OP_XOR:  w_ay = a ^ b;
      OP_ADD: begin
        w_t  = {1'b0, a} + {1'b0, b};
        w_ay = w_t[WIDTH-1:0];
        w_ac = w_t[WIDTH];
        w_av = (a[WIDTH-1] == b[WIDTH-1]) && (w_t[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_t  = {1'b0, a} - {1'b0, b};
        w_ay = w_t[WIDTH-1:0];
        w_ac = w_t[WIDTH];
        w_av = (a[WIDTH-1] != b[WIDTH-1]) && (w_t[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        w_t  = {1'b0, a} << w_sh;
        w_ay = w_t[WIDTH-1:0];
        w_ac = w_t[WIDTH];
      end
      OP_SHR: begin
        w_t  = {a, 1'b0} >> w_sh;
        w_ay = w_t[WIDTH:1];
        w_ac = w_t[0];
      end
      OP_ASR: begin
        w_t  = $signed({a, 1'b0}) >>> w_sh;
        w_ay = w_t[WIDTH:1];
        w_ac = w_t[0];
      end
      OP_MUL:  w_ay = '0;
      default: w_aerr = 1'b1;
    endcase
  end

  always_comb begin
    w_nflags = '0;
    if (w_ld_mul) begin
      w_ny            = w_prod[WIDTH-1:0];
      w_nyhi          = w_prod[2*WIDTH-1:WIDTH];
      w_nerr          = 1'b0;
      w_nflags[FLG_Z] = (w_prod == '0);
      w_nflags[FLG_N] = w_prod[2*WIDTH-1];
      w_nflags[FLG_V] = |w_prod[2*WIDTH-1:WIDTH];
    end else begin
      w_ny            = w_ay;
      w_nyhi          = '0;
      w_nerr          = w_aerr;
      w_nflags[FLG_Z] = !w_aerr && (w_ay == '0);
      w_nflags[FLG_N] = w_ay[WIDTH-1];
      w_nflags[FLG_C] = w_ac;
      w_nflags[FLG_V] = w_av;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_vld   <= 1'b0;
      r_y     <= '0;
      r_yhi   <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_vld   <= 1'b1;
        r_y     <= w_ny;
        r_yhi   <= w_nyhi;
        r_flags <= w_nflags;
        r_err   <= w_nerr;
      end else if (out_ready) begin
        r_vld   <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld;
  assign y         = r_y;
  assign y_hi      = r_yhi;
  assign flag_z    = r_flags[FLG_Z];
  assign flag_n    = r_flags[FLG_N];
  assign flag_c    = r_flags[FLG_C];
  assign flag_v    = r_flags[FLG_V];
  assign err       = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): reset, single-cycle ops, MUL latency,
// reset abort, backpressure hold, illegal opcode and back-to-back throughput.
module tb_alu_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y, y_hi;
  logic [3:0] op;
  logic       flag_z, flag_n, flag_c, flag_v, err, busy;
  logic [3:0] fl;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [3:0] fl;  // {V,C,N,Z}
  } vec_t;

  vec_t vt [11] = '{
    '{4'd0,  8'hF0, 8'h3C, 8'h30, 4'b0000},
    '{4'd1,  8'hF0, 8'h0F, 8'hFF, 4'b0010},
    '{4'd2,  8'hFF, 8'hFF, 8'h00, 4'b0001},
    '{4'd3,  8'h00, 8'h00, 8'hFF, 4'b0010},
    '{4'd7,  8'h0F, 8'h00, 8'hF0, 4'b0010},
    '{4'd8,  8'hAA, 8'hAA, 8'h00, 4'b0001},
    '{4'd9,  8'h81, 8'h01, 8'h02, 4'b0100},
    '{4'd10, 8'h5A, 8'h08, 8'h5A, 4'b0000},
    '{4'd10, 8'h81, 8'h01, 8'h40, 4'b0100},
    '{4'd5,  8'h80, 8'h01, 8'h7F, 4'b1000},
    '{4'd11, 8'h7F, 8'h07, 8'h00, 4'b0101}
  };

  logic [7:0] sb_q [$];

  assign fl = {flag_v, flag_c, flag_n, flag_z};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .y_hi     (y_hi),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .err      (err),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic res(input string tag, input logic [7:0] ey, input logic [7:0] eyhi,
                     input logic [3:0] efl, input logic eerr);
    chk(tag, {out_valid, y, y_hi, fl, err}, {1'b1, ey, eyhi, efl, eerr});
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] ta, input logic [7:0] tb);
    op = o; a = ta; b = tb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic       seen;
    logic [7:0] ta, tb, ey;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    #1;
    chk("reset_outs", {in_ready, out_valid, y, y_hi, fl, err, busy}, 24'h0);
    idle_cycles(2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", {in_ready, out_valid, busy}, 3'b100);

    issue(4'd4, 8'h7F, 8'h01);
    res("add_ovf", 8'h80, 8'h00, 4'b1010, 1'b0);
    issue(4'd4, 8'hFF, 8'h01);
    res("add_wrap", 8'h00, 8'h00, 4'b0101, 1'b0);
    issue(4'd5, 8'h03, 8'h05);
    res("sub_borrow", 8'hFE, 8'h00, 4'b0110, 1'b0);

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      res($sformatf("vec%0d", i), vt[i].y, 8'h00, vt[i].fl, 1'b0);
    end

    // MUL: accept at edge k, result after edge k+9
    issue(4'd6, 8'hFF, 8'hFF);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("mul_wait%0d", i), {out_valid, in_ready, busy}, 3'b001);
      if (i < 8) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    res("mul_ff", 8'h01, 8'hFE, 4'b1010, 1'b0);
    chk("mul_idle", {busy, in_ready}, 2'b01);

    // MUL aborted by reset in its fourth cycle
    issue(4'd6, 8'hFF, 8'hFF);
    idle_cycles(3);
    #2 rst = 1'b0;
    #1;
    chk("mul_rst_outs", {in_ready, out_valid, y, y_hi, fl, err, busy}, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("mul_rst_noresult", seen, 1'b0);
    chk("mul_rst_idle", in_ready, 1'b1);

    // Backpressure: result must hold, illegal op waits until drain
    out_ready = 1'b0;
    issue(4'd11, 8'h90, 8'h03);
    res("asr", 8'hF2, 8'h00, 4'b0010, 1'b0);
    op = 4'd13; a = 8'h55; b = 8'hAA; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), in_ready, 1'b0);
      @(posedge clk); #1;
      res($sformatf("bp_hold%0d", i), 8'hF2, 8'h00, 4'b0010, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_drain_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    res("illegal", 8'h00, 8'h00, 4'b0000, 1'b1);
    @(posedge clk); #1;
    chk("illegal_drop", out_valid, 1'b0);

    // Back-to-back ADD/XOR with a scoreboard
    for (int i = 0; i < 8; i++) begin
      ta = 8'(i * 37 + 11);
      tb = 8'(i * 91 + 200);
      if (i % 2 == 0) begin
        op = 4'd4; ey = 8'(ta + tb);
      end else begin
        op = 4'd8; ey = ta ^ tb;
      end
      a = ta; b = tb; in_valid = 1'b1;
      sb_q.push_back(ey);
      @(posedge clk); #1;
      chk($sformatf("b2b_vld%0d", i), out_valid, 1'b1);
      if (out_valid && sb_q.size() > 0) chk($sformatf("b2b_y%0d", i), y, sb_q.pop_front());
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", {out_valid, 8'(sb_q.size())}, 9'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
